// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the program counter, issues word fetches to
// instruction memory and queues returned instructions with their PCs toward decode.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = AW + 3;

  logic [31:0]   pc;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   tag_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] tag_wr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [SW-1:0] credit_sum;
  logic [SW-1:0] owed;
  logic          xfer;
  logic          push;
  logic          drop;
  logic          pop;

  // Stale responses still owed by memory keep their slots reserved, so a
  // request is only issued when every possible response is guaranteed a slot.
  assign credit_sum = SW'(count) + SW'(outstanding) + SW'(discard);
  assign owed       = SW'(discard) + SW'(outstanding) - SW'(imem_rvalid);

  assign imem_req  = ~reset & ~redirect_valid & (credit_sum < SW'(DEPTH));
  assign imem_addr = pc;
  assign xfer      = imem_req & imem_ready;

  // Responses return in order, so any nonzero discard count belongs to the
  // response currently on the bus.
  assign drop = ~reset & ~redirect_valid & imem_rvalid & (discard != '0);
  assign push = ~reset & ~redirect_valid & imem_rvalid & (discard == '0);

  assign ir_valid = ~reset & (count != '0);
  assign pop      = ir_valid & ir_ready & ~redirect_valid;
  assign ir       = ir_valid ? q_instr[rd_ptr] : '0;
  assign ir_pc    = ir_valid ? q_pc[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc & 32'hFFFF_FFFC;
      count       <= '0;
      outstanding <= '0;
      discard     <= CW'(owed);
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      if (xfer) begin
        pc     <= pc + 32'd4;
        tag_wr <= tag_wr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        tag_rd <= tag_rd + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop) begin
        discard <= discard - CW'(1);
      end
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(xfer) - CW'(push);
    end
  end

  // Storage needs no reset; the output mask hides it while the queue is empty.
  always_ff @(posedge clk) begin
    if (xfer) begin
      tag_mem[tag_wr] <= pc;
    end
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= tag_mem[tag_rd];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: in-order memory model with
// configurable latency plus a scoreboard of expected {pc, instruction} pairs.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  mem_req_t    pending[$];
  logic [31:0] exp_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] xfer_log[$];
  vec_t        vecs[8];
  logic [31:0] model_pc;
  int          checks;
  int          passed;
  int          cycle;
  int          lat;
  int          stale_owed;
  int          xfers;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir            (ir),
    .ir_pc         (ir_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  // Instruction word the memory model returns for an address; distinct from the
  // address so a swapped ir/ir_pc or a stale word is visible.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    else
      passed++;
  endtask

  task automatic checkPop(input string name, input int idx, input logic [31:0] expected);
    if (pop_log.size() > idx) begin
      checkOutput(name, pop_log[idx], expected);
    end else begin
      checks++;
      $display("[TB] FAIL %s: got only %0d pops, expected pop %0d with pc %h",
               name, pop_log.size(), idx, expected);
    end
  endtask

  task automatic checkXfer(input string name, input int idx, input logic [31:0] expected);
    if (xfer_log.size() > idx) begin
      checkOutput(name, xfer_log[idx], expected);
    end else begin
      checks++;
      $display("[TB] FAIL %s: got only %0d requests, expected request %0d at %h",
               name, xfer_log.size(), idx, expected);
    end
  endtask

  // Drives one cycle's inputs (called mid-cycle), then records the transfers
  // that the coming clock edge will perform and checks popped instructions.
  task automatic applyStimulus(input bit rst, input bit rdy, input bit mrdy,
                               input bit redir, input logic [31:0] rpc);
    logic [31:0] e;
    reset          = rst;
    ir_ready       = rdy;
    imem_ready     = mrdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (!rst && pending.size() > 0 && pending[0].due <= cycle) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(pending[0].addr);
      void'(pending.pop_front());
      if (stale_owed > 0) stale_owed--;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (rst) begin
      model_pc   = RESET_PC;
      stale_owed = 0;
      exp_q.delete();
      pending.delete();
    end else if (redir) begin
      checkOutput("req_in_redirect", 32'(imem_req), 32'd0);
      exp_q.delete();
      stale_owed = pending.size();
      model_pc   = {rpc[31:2], 2'b00};
    end else begin
      if (ir_valid && rdy) begin
        pop_log.push_back(ir_pc);
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_pop: got ir_pc %h, expected no valid entry", ir_pc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_ir_pc", ir_pc, e);
          checkOutput("sb_ir", ir, memWord(e));
        end
      end
      if (imem_req && mrdy) begin
        checkOutput("imem_addr", imem_addr, model_pc);
        pending.push_back('{addr: imem_addr, due: cycle + lat});
        exp_q.push_back(model_pc);
        xfer_log.push_back(imem_addr);
        model_pc = model_pc + 32'd4;
        xfers++;
        checkOutput("credit", 32'(exp_q.size() + stale_owed <= DEPTH), 32'd1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic doReset();
    repeat (2) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
    end
  endtask

  // Stops new fetches and lets decode consume everything still owed.
  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && pending.size() == 0) break;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput({name, "_idle"}, 32'(ir_valid), 32'd0);
    tick();
  endtask

  initial begin
    checks = 0; passed = 0; cycle = 0; lat = 1; stale_owed = 0; xfers = 0;
    model_pc = RESET_PC;
    reset = 1'b1; ir_ready = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset followed by free-running fetch against a 1-cycle memory.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        checkOutput($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("v%0d_valid", i), 32'(ir_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_ir_pc", i), ir_pc, vecs[i].exp_pc);
      checkOutput($sformatf("v%0d_ir", i), ir,
                  vecs[i].exp_valid ? memWord(vecs[i].exp_pc) : 32'h0);
      tick();
    end
    drain("free_drain");

    // Backpressure: decode stalls long enough for the queue to fill.
    doReset();
    xfers = 0;
    repeat (20) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
    end
    checkOutput("bp_xfers", 32'(xfers), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_req_low", 32'(imem_req), 32'd0);
    checkOutput("bp_head_pc", ir_pc, 32'h0);
    checkOutput("bp_head_ir", ir, memWord(32'h0));
    tick();
    pop_log.delete(); xfer_log.delete();
    repeat (12) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
    end
    checkPop("bp_pop0", 0, 32'h0);
    checkPop("bp_pop3", 3, 32'hC);
    checkXfer("bp_resume_addr", 0, 32'h10);
    drain("bp_drain");

    // Redirect while two requests are owed by a 3-cycle memory.
    doReset();
    lat = 3;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h20);
    tick();
    xfer_log.delete();
    repeat (2) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
    end
    checkXfer("rd_inflight0", 0, 32'h20);
    checkXfer("rd_inflight1", 1, 32'h24);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    tick();
    pop_log.delete();
    repeat (14) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
    end
    checkPop("rd_first", 0, 32'h100);
    checkPop("rd_second", 1, 32'h104);
    drain("rd_drain");

    // Unaligned redirect near the top of the address space.
    doReset();
    lat = 1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    tick();
    pop_log.delete(); xfer_log.delete();
    repeat (8) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
    end
    checkXfer("wrap_xfer0", 0, 32'hFFFF_FFFC);
    checkXfer("wrap_xfer1", 1, 32'h0000_0000);
    checkPop("wrap_pop0", 0, 32'hFFFF_FFFC);
    checkPop("wrap_pop1", 1, 32'h0000_0000);
    drain("wrap_drain");

    // Toggling memory acceptance with 3-cycle latency and random decode stalls.
    doReset();
    lat = 3;
    pop_log.delete();
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0), 1'(i % 2), 1'b0, 32'h0);
      tick();
    end
    checkOutput("tog_progress", 32'(pop_log.size() > 40), 32'd1);
    drain("tog_drain");

    // Redirect, pop and response all landing in the same cycle.
    doReset();
    lat = 1;
    repeat (6) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    checkOutput("sim_head_valid", 32'(ir_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("sim_empty", 32'(ir_valid), 32'd0);
    tick();
    pop_log.delete();
    repeat (8) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
    end
    checkPop("sim_pop0", 0, 32'h200);
    checkPop("sim_pop1", 1, 32'h204);
    drain("sim_drain");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
